data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Single-port 8-bit data memory with a fixed-latency request/done handshake. It services load and store requests from the core's memory stage. It produces the byte that the register-write-input selector forwards to the register file when a load retires (its DataOut feeds the selector's data-memory input). Every access takes a parameterised number of cycles, so the controller's pipeline stalls on Busy and resumes on Done.

## Interface
Parameters:
- AW, 8, address width; memory depth is 2**AW bytes
- DW, 8, data width
- LATENCY, 2, cycles from request acceptance to Done; legal range 1..15

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Req  input  1  access request; sampled only while Busy=0 and Done=0 or Done=1 (i.e. whenever Busy=0)
- WriteEn  input  1  1 = store, 0 = load; sampled with Req
- Addr  input  AW  byte address; sampled with Req
- DataIn  input  DW  store data; sampled with Req
- Busy  output  1  access in flight; requests ignored while high
- Done  output  1  one-cycle completion pulse
- DataOut  output  DW  last loaded byte; holds between loads

## Operation
- States: IDLE, BUSY.
- IDLE: Busy=0. If Req=1 at a rising edge, the block latches Addr, DataIn and WriteEn into internal registers. It then loads the down-counter with LATENCY-1 and enters BUSY.
- BUSY: Busy=1. Req and all other inputs are ignored. While the counter is nonzero it decrements each edge.
- Completion happens at the edge where the counter is zero while in BUSY:
  - Store: mem[latched Addr] <= latched DataIn; DataOut unchanged.
  - Load: DataOut <= mem[latched Addr].
  - The block asserts Done=1 for exactly the next cycle and returns to IDLE (Busy=0).
- The Done cycle is an IDLE cycle. A Req presented during the Done cycle is accepted at the following edge, so the back-to-back issue period is LATENCY+1 cycles.
- Inputs changing after acceptance have no effect on the in-flight access.
- Read-after-write to the same address returns the newly stored value, because the store commits at its completion edge.
- Addresses wrap naturally within 2**AW; there are no out-of-range checks.
- Counter width is 4 bits, which is sufficient for LATENCY≤15.

## Timing
- Reset (synchronous, takes priority over everything):
  - State=IDLE, Busy=0, Done=0, DataOut=0, counter=0, latched registers=0.
  - Memory contents are not cleared.
- Reset asserted while BUSY aborts the access. A pending store is not committed and no Done pulse is produced.
- Req accepted at edge E0 gives:
  - Busy=1 from E0 through E(LATENCY).
  - Busy=0 and Done=1 during the cycle after E(LATENCY).
  - DataOut valid from E(LATENCY) onward.
- LATENCY=1: Busy is high for exactly one cycle, then Done is high for one cycle.
- Done never stays high for two consecutive cycles.
- Busy and Done are never high together.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then idle: Busy=0, Done=0, DataOut=0x00 for 5 cycles with Req=0.
- Store 0xA5 to Addr 0x10, then load Addr 0x10 (LATENCY=2):
  - Busy is high for 2 cycles, then Done pulses.
  - The load's Done cycle shows DataOut=0xA5.
  - The store leaves DataOut unchanged.
- Back-to-back with Req held high, loads from 0x00, 0x01, 0x02 preloaded with 0x11, 0x22, 0x33:
  - Done pulses every 3 cycles.
  - DataOut steps 0x11, 0x22, 0x33.
  - Req while Busy spawns no extra access.
- Input change mid-flight: accept a store of 0x3C to 0x20, then change Addr to 0x21 and DataIn to 0xFF during BUSY. A later load of 0x20 returns 0x3C and a load of 0x21 returns its prior value.
- Reset mid-store: accept a store of 0x77 to 0x40 (prior value 0x12) and assert Reset in the first BUSY cycle.
  - No Done pulse occurs.
  - Outputs return to reset values.
  - A subsequent load of 0x40 returns 0x12.
- LATENCY=1 build, store 0xFF to 0xFF then load 0xFF: Busy is 1 cycle and Done 1 cycle per access, DataOut=0xFF, period 2 cycles.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Single-port byte memory behind a fixed-latency request/done handshake.
// One access is in flight at a time; Done pulses for one cycle as the block returns to idle.
module data_mem_ctrl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          write_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] data_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    // The counter starts at LATENCY-1 so that completion lands on edge E(LATENCY).
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    state_t        state_reg;
    logic [3:0]    count_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] data_reg;
    logic          we_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [DW-1:0] data_out_reg;

    logic [DW-1:0] mem [2**AW];

    logic complete;
    assign complete = (state_reg == BUSY) && (count_reg == 4'd0);

    // Storage is never reset; a reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (complete && we_reg && !reset) begin
            mem[addr_reg] <= data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= 4'd0;
            addr_reg     <= '0;
            data_reg     <= '0;
            we_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            data_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The Done cycle is idle too, which gives the LATENCY+1 issue period.
                    if (req) begin
                        addr_reg  <= addr;
                        data_reg  <= data_in;
                        we_reg    <= write_en;
                        count_reg <= COUNT_LOAD;
                        busy_reg  <= 1'b1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_reg != 4'd0) begin
                        count_reg <= count_reg - 4'd1;
                    end else begin
                        if (!we_reg) begin
                            data_out_reg <= mem[addr_reg];
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign data_out = data_out_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl: a LATENCY=2 instance (a_*) and a LATENCY=1 instance (b_*)
// checked against a flat array model of memory contents and the last loaded byte.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_req, a_we, a_busy, a_done;
    logic [7:0] a_addr, a_din, a_dout;
    logic       b_req, b_we, b_busy, b_done;
    logic [7:0] b_addr, b_din, b_dout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_a [256];
    logic [7:0] model_b [256];
    logic [7:0] exp_a;
    logic [7:0] exp_b;

    data_mem_ctrl #(.AW(8), .DW(8), .LATENCY(2)) dut_a (
        .clk(clk), .reset(rst), .req(a_req), .write_en(a_we), .addr(a_addr),
        .data_in(a_din), .busy(a_busy), .done(a_done), .data_out(a_dout)
    );

    data_mem_ctrl #(.AW(8), .DW(8), .LATENCY(1)) dut_b (
        .clk(clk), .reset(rst), .req(b_req), .write_en(b_we), .addr(b_addr),
        .data_in(b_din), .busy(b_busy), .done(b_done), .data_out(b_dout)
    );

    task automatic drive(input bit use_b, input bit rq, input bit we, input logic [7:0] ad, input logic [7:0] d);
        if (use_b) begin
            b_req = rq; b_we = we; b_addr = ad; b_din = d;
        end else begin
            a_req = rq; a_we = we; a_addr = ad; a_din = d;
        end
    endtask

    task automatic sample(input bit use_b, output logic bsy, output logic dn, output logic [7:0] o);
        bsy = use_b ? b_busy : a_busy;
        dn  = use_b ? b_done : a_done;
        o   = use_b ? b_dout : a_dout;
    endtask

    // Issues one access and reports what was observed: busy cycles, done cycles (including one
    // cycle after the pulse), data_out during the done cycle, busy/done overlap and timeout.
    task automatic access(input bit use_b, input bit we, input logic [7:0] ad, input logic [7:0] d,
                          output int busy_n, output int done_n, output logic [7:0] dout,
                          output bit overlap, output bit timeout);
        logic bsy, dn;
        logic [7:0] o;
        busy_n = 0; done_n = 0; dout = 8'h00; overlap = 1'b0; timeout = 1'b1;
        @(negedge clk);
        drive(use_b, 1'b1, we, ad, d);
        @(negedge clk);
        drive(use_b, 1'b0, 1'b0, ad, d);
        for (int k = 0; k < 40; k++) begin
            sample(use_b, bsy, dn, o);
            if (bsy && dn) overlap = 1'b1;
            if (bsy) begin
                busy_n++;
            end else if (dn) begin
                done_n++;
                dout = o;
                @(negedge clk);
                sample(use_b, bsy, dn, o);
                if (dn) done_n++;
                if (bsy) busy_n++;
                timeout = 1'b0;
                break;
            end else begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_a = 8'h00;
        exp_b = 8'h00;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({a_busy, a_done, a_dout} !== 10'h000) begin
                failures++;
                $display("FAIL reset_idle_a cycle=%0d busy=%0b done=%0b dout=%02h expected 0/0/00", c, a_busy, a_done, a_dout);
            end
            checks++;
            if ({b_busy, b_done, b_dout} !== 10'h000) begin
                failures++;
                $display("FAIL reset_idle_b cycle=%0d busy=%0b done=%0b dout=%02h expected 0/0/00", c, b_busy, b_done, b_dout);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_load();
        int bn, dn; logic [7:0] o; bit ov, to;
        access(1'b0, 1'b1, 8'h10, 8'hA5, bn, dn, o, ov, to);
        model_a[8'h10] = 8'hA5;
        checks++;
        if (bn != 2 || dn != 1 || ov || to) begin
            failures++;
            $display("FAIL store_timing busy=%0d done=%0d ov=%0b to=%0b expected busy=2 done=1", bn, dn, ov, to);
        end
        checks++;
        if (o !== exp_a) begin
            failures++;
            $display("FAIL store_dout_unchanged got=%02h expected=%02h", o, exp_a);
        end
        access(1'b0, 1'b0, 8'h10, 8'h00, bn, dn, o, ov, to);
        exp_a = model_a[8'h10];
        checks++;
        if (bn != 2 || dn != 1 || ov || to) begin
            failures++;
            $display("FAIL load_timing busy=%0d done=%0d ov=%0b to=%0b expected busy=2 done=1", bn, dn, ov, to);
        end
        checks++;
        if (o !== 8'hA5) begin
            failures++;
            $display("FAIL load_after_store got=%02h expected=a5", o);
        end
    endtask

    task automatic test_back_to_back();
        int bn, dn; logic [7:0] o; bit ov, to;
        logic [7:0] vals [3];
        int done_at [$];
        logic [7:0] seen [$];
        int busy_after;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b1, 8'(i), vals[i], bn, dn, o, ov, to);
            model_a[i] = vals[i];
            checks++;
            if (bn != 2 || dn != 1 || ov || to) begin
                failures++;
                $display("FAIL b2b_preload_timing addr=%0d busy=%0d done=%0d", i, bn, dn);
            end
        end
        busy_after = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_at.size() == 3 && a_busy) busy_after++;
            if (a_done) begin
                done_at.push_back(c);
                seen.push_back(a_dout);
                if (seen.size() < 3) drive(1'b0, 1'b1, 1'b0, 8'(seen.size()), 8'h00);
                else drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        exp_a = model_a[2];
        checks++;
        if (done_at.size() != 3 || busy_after != 0) begin
            failures++;
            $display("FAIL b2b_count dones=%0d busy_after=%0d expected dones=3 busy_after=0", done_at.size(), busy_after);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== model_a[i]) begin
                    failures++;
                    $display("FAIL b2b_data idx=%0d got=%02h expected=%02h", i, seen[i], model_a[i]);
                end
            end
            checks++;
            if (done_at[1] - done_at[0] != 3 || done_at[2] - done_at[1] != 3) begin
                failures++;
                $display("FAIL b2b_period gaps=%0d,%0d expected 3,3", done_at[1] - done_at[0], done_at[2] - done_at[1]);
            end
        end
    endtask

    task automatic test_midflight();
        int bn, dn; logic [7:0] o; bit ov, to;
        int dones;
        access(1'b0, 1'b1, 8'h21, 8'h5A, bn, dn, o, ov, to);
        model_a[8'h21] = 8'h5A;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h3C);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h21, 8'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 8'h21, 8'hFF);
        model_a[8'h20] = 8'h3C;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL midflight_dones got=%0d expected=1", dones);
        end
        access(1'b0, 1'b0, 8'h20, 8'h00, bn, dn, o, ov, to);
        exp_a = model_a[8'h20];
        checks++;
        if (o !== exp_a || to) begin
            failures++;
            $display("FAIL midflight_load20 got=%02h expected=%02h", o, exp_a);
        end
        access(1'b0, 1'b0, 8'h21, 8'h00, bn, dn, o, ov, to);
        exp_a = model_a[8'h21];
        checks++;
        if (o !== exp_a || to) begin
            failures++;
            $display("FAIL midflight_load21 got=%02h expected=%02h", o, exp_a);
        end
    endtask

    task automatic test_reset_midstore();
        int bn, dn; logic [7:0] o; bit ov, to;
        int dones;
        access(1'b0, 1'b1, 8'h40, 8'h12, bn, dn, o, ov, to);
        model_a[8'h40] = 8'h12;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h77);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_a = 8'h00;
        exp_b = 8'h00;
        checks++;
        if ({a_busy, a_done, a_dout} !== 10'h000) begin
            failures++;
            $display("FAIL reset_midstore_outputs busy=%0b done=%0b dout=%02h expected 0/0/00", a_busy, a_done, a_dout);
        end
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (a_done || a_busy) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_midstore_activity got=%0d expected=0", dones);
        end
        access(1'b0, 1'b0, 8'h40, 8'h00, bn, dn, o, ov, to);
        exp_a = model_a[8'h40];
        checks++;
        if (o !== 8'h12 || to) begin
            failures++;
            $display("FAIL reset_midstore_load got=%02h expected=12", o);
        end
    endtask

    task automatic test_latency1();
        int bn, dn; logic [7:0] o; bit ov, to;
        int done_at [$];
        access(1'b1, 1'b1, 8'hFF, 8'hFF, bn, dn, o, ov, to);
        model_b[8'hFF] = 8'hFF;
        checks++;
        if (bn != 1 || dn != 1 || ov || to || o !== exp_b) begin
            failures++;
            $display("FAIL lat1_store busy=%0d done=%0d dout=%02h expected busy=1 done=1 dout=%02h", bn, dn, o, exp_b);
        end
        access(1'b1, 1'b0, 8'hFF, 8'h00, bn, dn, o, ov, to);
        exp_b = model_b[8'hFF];
        checks++;
        if (bn != 1 || dn != 1 || ov || to || o !== 8'hFF) begin
            failures++;
            $display("FAIL lat1_load busy=%0d done=%0d dout=%02h expected busy=1 done=1 dout=ff", bn, dn, o);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (b_done) begin
                done_at.push_back(c);
                if (done_at.size() == 3) drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
            end
        end
        checks++;
        if (done_at.size() != 3) begin
            failures++;
            $display("FAIL lat1_count dones=%0d expected=3", done_at.size());
        end else begin
            checks++;
            if (done_at[1] - done_at[0] != 2 || done_at[2] - done_at[1] != 2) begin
                failures++;
                $display("FAIL lat1_period gaps=%0d,%0d expected 2,2", done_at[1] - done_at[0], done_at[2] - done_at[1]);
            end
        end
    endtask

    task automatic test_random();
        int bn, dn; logic [7:0] o; bit ov, to;
        bit we; logic [7:0] ad, d;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            access(1'b0, 1'b1, 8'(i), d, bn, dn, o, ov, to);
            model_a[i] = d;
            checks++;
            if (bn != 2 || dn != 1 || ov || to || o !== exp_a) begin
                failures++;
                $display("FAIL preload addr=%02h busy=%0d done=%0d dout=%02h expected busy=2 done=1 dout=%02h", i, bn, dn, o, exp_a);
            end
        end
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            access(1'b1, 1'b1, 8'(8'hF0 + i), d, bn, dn, o, ov, to);
            model_b[8'hF0 + i] = d;
        end
        for (int i = 0; i < 100; i++) begin
            we = 1'($urandom);
            ad = 8'($urandom);
            d  = 8'($urandom);
            access(1'b0, we, ad, d, bn, dn, o, ov, to);
            if (we) model_a[ad] = d;
            else exp_a = model_a[ad];
            checks++;
            if (bn != 2 || dn != 1 || ov || to || o !== exp_a) begin
                failures++;
                $display("FAIL rand_a we=%0b addr=%02h busy=%0d done=%0d dout=%02h expected busy=2 done=1 dout=%02h", we, ad, bn, dn, o, exp_a);
            end
        end
        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom);
            ad = 8'($urandom_range(8'hF0, 8'hFF));
            d  = 8'($urandom);
            access(1'b1, we, ad, d, bn, dn, o, ov, to);
            if (we) model_b[ad] = d;
            else exp_b = model_b[ad];
            checks++;
            if (bn != 1 || dn != 1 || ov || to || o !== exp_b) begin
                failures++;
                $display("FAIL rand_b we=%0b addr=%02h busy=%0d done=%0d dout=%02h expected busy=1 done=1 dout=%02h", we, ad, bn, dn, o, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_midflight();
        test_reset_midstore();
        test_latency1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
